// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the two-stage accumulator CPU:
//                compute-instruction control bit positions and the ALU
//                operation encoding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Control bit positions inside a compute instruction (top bit set)
    localparam int BIT_JL       = 0;
    localparam int BIT_JE       = 1;
    localparam int BIT_JG       = 2;
    localparam int BIT_ST_RAM   = 3;
    localparam int BIT_ST_D     = 4;
    localparam int BIT_ST_A     = 5;
    localparam int BIT_INV_RES  = 6;
    localparam int BIT_OP       = 7;
    localparam int BIT_INV_RHS  = 8;
    localparam int BIT_ZERO_RHS = 9;
    localparam int BIT_INV_LHS  = 10;
    localparam int BIT_ZERO_LHS = 11;
    localparam int BIT_RHS_SEL  = 12;

    typedef enum logic {
        OP_AND = 1'b0,
        OP_ADD = 1'b1
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
// ============================================================================
//  Module      : cpu_alu
//  Description : Combinational ALU. Each operand is optionally zeroed and
//                then optionally inverted, combined by AND or wrapping ADD,
//                and the result is optionally inverted. Sign/zero flags are
//                derived from the final result.
//  Ports       : lhs, rhs            operands (WIDTH)
//                zero_*/inv_*        operand conditioning controls
//                op                  OP_AND / OP_ADD
//                inv_res             invert final result
//                result              ALU output (WIDTH)
//                lt, eq, gt          result <0, ==0, >0 (two's complement)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic             zero_lhs,
    input  logic             inv_lhs,
    input  logic             zero_rhs,
    input  logic             inv_rhs,
    input  alu_op_e          op,
    input  logic             inv_res,
    output logic [WIDTH-1:0] result,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    logic [WIDTH-1:0] w_lhs_z;
    logic [WIDTH-1:0] w_lhs;
    logic [WIDTH-1:0] w_rhs_z;
    logic [WIDTH-1:0] w_rhs;
    logic [WIDTH-1:0] w_raw;

    // Zero first, then invert: zero+invert yields all ones
    assign w_lhs_z = zero_lhs ? '0 : lhs;
    assign w_lhs   = inv_lhs ? ~w_lhs_z : w_lhs_z;
    assign w_rhs_z = zero_rhs ? '0 : rhs;
    assign w_rhs   = inv_rhs ? ~w_rhs_z : w_rhs_z;

    // ADD discards the carry out (wraps modulo 2^WIDTH)
    assign w_raw   = (op == OP_ADD) ? (w_lhs + w_rhs) : (w_lhs & w_rhs);
    assign result  = inv_res ? ~w_raw : w_raw;

    assign lt = result[WIDTH-1];
    assign eq = (result == '0);
    assign gt = ~lt & ~eq;

endmodule

`default_nettype wire

// File: rtl/cpu_pipe.sv
// ============================================================================
//  Module      : cpu_pipe
//  Description : Two-stage (fetch / execute) accumulator CPU with A and D
//                registers and a small data RAM addressed by A. Taken jumps
//                flush the fetched instruction (one bubble). Optional halt
//                detection on self-jumps is enabled by defining the macro
//                CPU_HALT_DETECT_EN; without it halted is tied low.
//  Ports       : clk         rising-edge clock
//                reset       synchronous, active-high
//                instr_addr  program ROM address (= PC), PROG_AW bits
//                instr       combinational ROM data, WIDTH bits
//                retired     high while a valid instruction executes
//                halted      sticky self-jump halt flag
//                dbg_a       current A register
//                dbg_d       current D register
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_pipe
    import cpu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int RAM_AW  = 3,
    parameter int PROG_AW = 6
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PROG_AW-1:0] instr_addr,
    input  logic [WIDTH-1:0]   instr,
    output logic               retired,
    output logic               halted,
    output logic [WIDTH-1:0]   dbg_a,
    output logic [WIDTH-1:0]   dbg_d
);

`ifdef CPU_HALT_DETECT_EN
    localparam logic c_halt_en = 1'b1;
`else
    localparam logic c_halt_en = 1'b0;
`endif

    localparam logic [PROG_AW-1:0] c_pc_one = PROG_AW'(1);

    // Fetch stage / pipeline registers
    logic [PROG_AW-1:0] r_pc;
    logic [WIDTH-1:0]   r_ir;
    logic [PROG_AW-1:0] r_ir_pc;
    logic               r_ir_valid;
    logic               r_halted;

    // Architectural state
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_ram [0:(2**RAM_AW)-1];

    // Execute-stage decode
    logic               w_exec;
    logic               w_is_comp;
    logic [RAM_AW-1:0]  w_ram_addr;
    logic [WIDTH-1:0]   w_ram_rd;
    logic [WIDTH-1:0]   w_rhs;
    logic [WIDTH-1:0]   w_result;
    logic               w_lt;
    logic               w_eq;
    logic               w_gt;
    logic               w_cond;
    logic               w_taken;
    logic [PROG_AW-1:0] w_target;
    logic               w_halt_hit;
    logic               w_wr_a;
    logic               w_wr_d;
    logic               w_wr_ram;
    logic [WIDTH-1:0]   w_a_next;

    // Reset suppresses execution so no write lands in a reset cycle
    assign w_exec     = r_ir_valid & ~reset;
    assign w_is_comp  = r_ir[WIDTH-1];

    // RAM address, jump target and rhs all use A before this instruction's write
    assign w_ram_addr = r_a[RAM_AW-1:0];
    assign w_ram_rd   = r_ram[w_ram_addr];
    assign w_rhs      = r_ir[BIT_RHS_SEL] ? w_ram_rd : r_a;
    assign w_target   = r_a[PROG_AW-1:0];

    cpu_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .lhs      (r_d),
        .rhs      (w_rhs),
        .zero_lhs (r_ir[BIT_ZERO_LHS]),
        .inv_lhs  (r_ir[BIT_INV_LHS]),
        .zero_rhs (r_ir[BIT_ZERO_RHS]),
        .inv_rhs  (r_ir[BIT_INV_RHS]),
        .op       (alu_op_e'(r_ir[BIT_OP])),
        .inv_res  (r_ir[BIT_INV_RES]),
        .result   (w_result),
        .lt       (w_lt),
        .eq       (w_eq),
        .gt       (w_gt)
    );

    assign w_cond     = (r_ir[BIT_JL] & w_lt) | (r_ir[BIT_JE] & w_eq) | (r_ir[BIT_JG] & w_gt);
    assign w_taken    = w_exec & w_is_comp & w_cond;
    assign w_halt_hit = c_halt_en & w_taken & (w_target == r_ir_pc);

    assign w_wr_a     = w_exec & (~w_is_comp | r_ir[BIT_ST_A]);
    assign w_wr_d     = w_exec & w_is_comp & r_ir[BIT_ST_D];
    assign w_wr_ram   = w_exec & w_is_comp & r_ir[BIT_ST_RAM];
    assign w_a_next   = w_is_comp ? w_result : {1'b0, r_ir[WIDTH-2:0]};

    // Fetch / PC / flush / halt control
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else if (r_halted) begin
            // Frozen: PC holds the self-jump target, nothing enters E
            r_ir_valid <= 1'b0;
        end else if (w_taken) begin
            r_pc       <= w_target;
            r_ir_valid <= 1'b0;
            r_halted   <= w_halt_hit;
        end else begin
            r_ir       <= instr;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= r_pc + c_pc_one;
        end
    end

    // Register file
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= '0;
            r_d <= '0;
        end else begin
            if (w_wr_a) begin
                r_a <= w_a_next;
            end
            if (w_wr_d) begin
                r_d <= w_result;
            end
        end
    end

    // Data RAM: contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_ram_addr] <= w_result;
        end
    end

    assign instr_addr = r_pc;
    assign retired    = w_exec;
    assign halted     = r_halted & c_halt_en;
    assign dbg_a      = r_a;
    assign dbg_d      = r_d;

endmodule

`default_nettype wire

// File: tb/tb_cpu_pipe.sv
// ============================================================================
//  Module      : tb_cpu_pipe
//  Description : Self-checking bench for cpu_pipe. A 16-bit core is compared
//                every cycle against an instruction-level model; a 24-bit
//                core exercises the wide immediate and reset mid-program.
//                Literal expectations pin key points of each program.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_pipe;

`ifdef CPU_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- 16-bit DUT ----------------
    logic        rst16 = 1'b1;
    logic [5:0]  addr16;
    logic [15:0] instr16;
    logic        ret16;
    logic        halt16;
    logic [15:0] a16;
    logic [15:0] d16;
    logic [15:0] rom16 [0:63];

    assign instr16 = rom16[addr16];

    cpu_pipe #(.WIDTH(16), .RAM_AW(3), .PROG_AW(6)) dut16 (
        .clk        (clk),
        .reset      (rst16),
        .instr_addr (addr16),
        .instr      (instr16),
        .retired    (ret16),
        .halted     (halt16),
        .dbg_a      (a16),
        .dbg_d      (d16)
    );

    // ---------------- 24-bit DUT ----------------
    logic        rst24 = 1'b1;
    logic [5:0]  addr24;
    logic [23:0] instr24;
    logic        ret24;
    logic        halt24;
    logic [23:0] a24;
    logic [23:0] d24;
    logic [23:0] rom24 [0:63];

    assign instr24 = rom24[addr24];

    cpu_pipe #(.WIDTH(24), .RAM_AW(3), .PROG_AW(6)) dut24 (
        .clk        (clk),
        .reset      (rst24),
        .instr_addr (addr24),
        .instr      (instr24),
        .retired    (ret24),
        .halted     (halt24),
        .dbg_a      (a24),
        .dbg_d      (d24)
    );

    // ---------------- instruction-level model (16-bit) ----------------
    function automatic logic [15:0] alu_ref(input logic [15:0] ins,
                                            input logic [15:0] d,
                                            input logic [15:0] rv);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        x = ins[11] ? 16'h0 : d;
        if (ins[10]) x = ~x;
        y = ins[9] ? 16'h0 : rv;
        if (ins[8]) y = ~y;
        r = ins[7] ? (x + y) : (x & y);
        if (ins[6]) r = ~r;
        return r;
    endfunction

    function automatic bit jump_ref(input logic [15:0] ins, input logic [15:0] r);
        return (ins[0] && r[15]) || (ins[1] && r == 16'h0) ||
               (ins[2] && !r[15] && r != 16'h0);
    endfunction

    logic [5:0]  m_pc;
    logic [5:0]  m_irpc;
    logic [15:0] m_ir;
    logic [15:0] m_a;
    logic [15:0] m_d;
    logic [15:0] m_old_a;
    logic [15:0] m_res;
    logic [15:0] m_ram [0:7];
    bit          m_valid = 1'b0;
    bit          m_halt  = 1'b0;
    bit          m_known = 1'b0;
    bit          m_take;

    initial begin
        forever begin
            @(posedge clk);
            if (rst16) begin
                m_pc    = 6'd0;
                m_valid = 1'b0;
                m_a     = 16'h0;
                m_d     = 16'h0;
                m_halt  = 1'b0;
                m_known = 1'b1;
            end else if (!m_halt) begin
                m_take  = 1'b0;
                m_old_a = m_a;
                if (m_valid) begin
                    if (!m_ir[15]) begin
                        m_a = {1'b0, m_ir[14:0]};
                    end else begin
                        m_res  = alu_ref(m_ir, m_d, m_ir[12] ? m_ram[m_old_a[2:0]] : m_old_a);
                        m_take = jump_ref(m_ir, m_res);
                        if (m_ir[3]) m_ram[m_old_a[2:0]] = m_res;
                        if (m_ir[4]) m_d = m_res;
                        if (m_ir[5]) m_a = m_res;
                    end
                end
                if (m_take) begin
                    if (HALT_EN && m_old_a[5:0] == m_irpc) m_halt = 1'b1;
                    m_pc    = m_old_a[5:0];
                    m_valid = 1'b0;
                end else begin
                    m_ir    = rom16[m_pc];
                    m_irpc  = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 6'd1;
                end
            end
        end
    end

    // Per-cycle compare of the 16-bit core against the model
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (m_known) begin
                n_vec++;
                if (addr16 !== m_pc || ret16 !== (m_valid && !rst16) ||
                    halt16 !== m_halt || a16 !== m_a || d16 !== m_d) begin
                    n_err++;
                    $display("FAIL cycle t=%0t: got addr=%0d ret=%b halt=%b a=%h d=%h expected addr=%0d ret=%b halt=%b a=%h d=%h",
                             $time, addr16, ret16, halt16, a16, d16,
                             m_pc, (m_valid && !rst16), m_halt, m_a, m_d);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset16();
        rst16 = 1'b1;
        step(2);
        rst16 = 1'b0;
    endtask

    task automatic clear16();
        for (int i = 0; i < 64; i++) rom16[i] = 16'h0000;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        clear16();
        for (int i = 0; i < 64; i++) rom24[i] = 24'h0;
        step(1);

        // Load and copy
        clear16();
        rom16[0] = 16'h0005;
        rom16[1] = 16'h8890;
        reset16();
        chk("reset_addr", 32'(addr16), 32'd0);
        chk("reset_ret", 32'(ret16), 32'd0);
        chk("reset_halt", 32'(halt16), 32'd0);
        chk("reset_a", 32'(a16), 32'd0);
        chk("reset_d", 32'(d16), 32'd0);
        step(1);
        chk("copy_ret_c2", 32'(ret16), 32'd1);
        step(1);
        chk("copy_ret_c3", 32'(ret16), 32'd1);
        chk("copy_a_e2", 32'(a16), 32'd5);
        step(1);
        chk("copy_a", 32'(a16), 32'd5);
        chk("copy_d", 32'(d16), 32'd5);
        step(70);       // run past the PC wrap under the per-cycle compare
        chk("wrap_d", 32'(d16), 32'd5);

        // RAM round trip
        clear16();
        rom16[0] = 16'h0002;
        rom16[1] = 16'h8888;
        rom16[2] = 16'h9890;
        reset16();
        step(4);
        chk("ram_d", 32'(d16), 32'd2);
        chk("ram_a", 32'(a16), 32'd2);

        // Unconditional jump
        clear16();
        rom16[0] = 16'h0004;
        rom16[1] = 16'h8007;
        rom16[2] = 16'h8890;
        rom16[3] = 16'h8890;
        rom16[4] = 16'h0009;
        reset16();
        chk("jmp_addr0", 32'(addr16), 32'd0);
        step(1);
        chk("jmp_addr1", 32'(addr16), 32'd1);
        step(1);
        chk("jmp_addr2", 32'(addr16), 32'd2);
        chk("jmp_ret", 32'(ret16), 32'd1);
        step(1);
        chk("jmp_addr4", 32'(addr16), 32'd4);
        chk("jmp_bubble", 32'(ret16), 32'd0);
        step(1);
        chk("jmp_addr5", 32'(addr16), 32'd5);
        step(1);
        chk("jmp_a", 32'(a16), 32'd9);
        chk("jmp_d_flushed", 32'(d16), 32'd0);

        // Conditional not taken (D = A = 3, je), then je taken on zero result
        clear16();
        rom16[0] = 16'h0003;
        rom16[1] = 16'h8892;
        rom16[2] = 16'h0006;
        rom16[3] = 16'h8A92;
        rom16[4] = 16'h0001;
        rom16[6] = 16'h0007;
        reset16();
        step(3);
        chk("cond_d", 32'(d16), 32'd3);
        chk("cond_ret", 32'(ret16), 32'd1);
        chk("cond_addr", 32'(addr16), 32'd3);
        step(2);
        chk("je_addr", 32'(addr16), 32'd6);
        chk("je_bubble", 32'(ret16), 32'd0);
        chk("je_d", 32'(d16), 32'd0);
        chk("je_a", 32'(a16), 32'd6);
        step(2);
        chk("je_a_after", 32'(a16), 32'd7);

        // Self-jump
        clear16();
        rom16[0] = 16'h0001;
        rom16[1] = 16'h8007;
        reset16();
        step(2);
        chk("self_jump_ret", 32'(ret16), 32'd1);
        step(1);
`ifdef CPU_HALT_DETECT_EN
        chk("halt_set", 32'(halt16), 32'd1);
        chk("halt_addr", 32'(addr16), 32'd1);
        chk("halt_ret", 32'(ret16), 32'd0);
        step(4);
        chk("halt_hold", 32'(halt16), 32'd1);
        chk("halt_addr_frozen", 32'(addr16), 32'd1);
        chk("halt_ret_quiet", 32'(ret16), 32'd0);
        rst16 = 1'b1;
        step(1);
        chk("halt_clear", 32'(halt16), 32'd0);
        chk("halt_reset_addr", 32'(addr16), 32'd0);
        rst16 = 1'b0;
`else
        chk("loop_halt", 32'(halt16), 32'd0);
        chk("loop_addr", 32'(addr16), 32'd1);
        chk("loop_bubble", 32'(ret16), 32'd0);
        step(1);
        chk("loop_ret", 32'(ret16), 32'd1);
        chk("loop_addr2", 32'(addr16), 32'd2);
        step(1);
        chk("loop_bubble2", 32'(ret16), 32'd0);
        chk("loop_addr3", 32'(addr16), 32'd1);
`endif
        step(2);

        // 24-bit core: reset mid-program
        rom24[0] = 24'h7FFFFF;
        rom24[1] = 24'h800890;
        rst24 = 1'b1;
        step(2);
        rst24 = 1'b0;
        step(2);
        chk("w24_a_imm", 32'(a24), 32'h7FFFFF);
        chk("w24_d_pre", 32'(d24), 32'h0);
        chk("w24_ret_pre", 32'(ret24), 32'd1);
        rst24 = 1'b1;
        step(1);
        chk("w24_d_reset", 32'(d24), 32'h0);
        chk("w24_a_reset", 32'(a24), 32'h0);
        chk("w24_ret_reset", 32'(ret24), 32'd0);
        chk("w24_halt", 32'(halt24), 32'd0);
        rst24 = 1'b0;
        step(2);
        chk("w24_a_reload", 32'(a24), 32'h7FFFFF);
        step(1);
        chk("w24_d_store", 32'(d24), 32'h7FFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
